// File: rtl/pcie_init_pkg.sv
// Shared types and widths for the PCIe init/reset sequencer.
package pcie_init_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned HOLD_CNT_W = 16;
  localparam int unsigned WAIT_CNT_W = 24;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT_POR   = 3'd0,
    ST_WAIT_INIT  = 3'd1,
    ST_WAIT_CALIB = 3'd2,
    ST_WAIT_LOCK  = 3'd3,
    ST_HOLD       = 3'd4,
    ST_STAGGER    = 3'd5,
    ST_RUN        = 3'd6
  } init_state_e;

endpackage

// File: rtl/pcie_init_sync.sv
// Multi-flop single-bit synchronizer with synchronous active-low clear.
module pcie_init_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous input through the chain; clear to 0 on reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pcie_init_reset_sequencer.sv
// Synchronizes init-monitor status and PLL lock, then releases the fabric
// reset and, after a stagger delay, the PCIe user-logic reset.
module pcie_init_reset_sequencer
  import pcie_init_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned HOLD_CYCLES    = 256,
  parameter int unsigned STAGGER_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               FABRIC_POR_N,
  input  logic               PCIE_INIT_DONE,
  input  logic               DEVICE_INIT_DONE,
  input  logic               BANK_0_CALIB_STATUS,
  input  logic               BANK_1_CALIB_STATUS,
  input  logic               PLL_LOCK,
  output logic               FABRIC_RESET_N,
  output logic               PCIE_RESET_N,
  output logic [STATE_W-1:0] INIT_STATE,
  output logic               TIMEOUT,
  output logic               READY
);

  localparam int unsigned N_IN = 6;
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST    = HOLD_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_CNT_W-1:0] STAGGER_LAST = HOLD_CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST    = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [N_IN-1:0] async_in;
  logic [N_IN-1:0] in_s;
  logic por_s, pcie_init_s, dev_init_s, calib0_s, calib1_s, lock_s;

  init_state_e             state_q, state_d;
  logic [HOLD_CNT_W-1:0]   phase_cnt_q, phase_cnt_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    timeout_q, timeout_d;
  logic                    fabric_rst_n_q, pcie_rst_n_q, ready_q;
  logic                    locked_phase, count_phase, wait_phase;
  logic [HOLD_CNT_W-1:0]   phase_last;

  assign async_in = {FABRIC_POR_N, PCIE_INIT_DONE, DEVICE_INIT_DONE,
                     BANK_0_CALIB_STATUS, BANK_1_CALIB_STATUS, PLL_LOCK};

  // One synchronizer chain per asynchronous status input.
  for (genvar i = 0; i < N_IN; i++) begin : g_sync
    pcie_init_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i  (CLK),
      .rst_ni (RESETN),
      .d_i    (async_in[i]),
      .q_o    (in_s[i])
    );
  end

  assign {por_s, pcie_init_s, dev_init_s, calib0_s, calib1_s, lock_s} = in_s;

  // Next-state, phase counter and wait/timeout counter logic.
  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;

    locked_phase = (state_q == ST_HOLD) || (state_q == ST_STAGGER) || (state_q == ST_RUN);
    count_phase  = (state_q == ST_HOLD) || (state_q == ST_STAGGER);
    wait_phase   = (state_q == ST_WAIT_INIT) || (state_q == ST_WAIT_CALIB) ||
                   (state_q == ST_WAIT_LOCK);
    phase_last   = (state_q == ST_HOLD) ? HOLD_LAST : STAGGER_LAST;

    case (state_q)
      ST_WAIT_POR:   if (por_s) state_d = ST_WAIT_INIT;
      ST_WAIT_INIT:  if (pcie_init_s && dev_init_s) state_d = ST_WAIT_CALIB;
      ST_WAIT_CALIB: if (calib0_s && calib1_s) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK:  if (lock_s) state_d = ST_HOLD;
      ST_HOLD:       if (phase_cnt_q == HOLD_LAST) state_d = ST_STAGGER;
      ST_STAGGER:    if (phase_cnt_q == STAGGER_LAST) state_d = ST_RUN;
      ST_RUN:        state_d = ST_RUN;
      default:       state_d = ST_WAIT_POR;
    endcase

    // Aborts override normal progress; POR loss outranks lock loss.
    if (!por_s) begin
      state_d = ST_WAIT_POR;
    end else if (!lock_s && locked_phase) begin
      state_d = ST_WAIT_LOCK;
    end

    // Phase counter restarts on every state change and saturates at its terminal count.
    if (state_d != state_q) begin
      phase_cnt_d = '0;
    end else if (count_phase && (phase_cnt_q != phase_last)) begin
      phase_cnt_d = phase_cnt_q + HOLD_CNT_W'(1);
    end

    // Wait counter restarts on every state change and saturates once it reaches the limit.
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (wait_phase && (wait_cnt_q != WAIT_LAST)) begin
      wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
    end

    if (wait_phase && (wait_cnt_q == WAIT_LAST)) begin
      timeout_d = 1'b1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q        <= ST_WAIT_POR;
      phase_cnt_q    <= '0;
      wait_cnt_q     <= '0;
      timeout_q      <= 1'b0;
      fabric_rst_n_q <= 1'b0;
      pcie_rst_n_q   <= 1'b0;
      ready_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_cnt_q    <= phase_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      timeout_q      <= timeout_d;
      fabric_rst_n_q <= (state_d == ST_STAGGER) || (state_d == ST_RUN);
      pcie_rst_n_q   <= (state_d == ST_RUN);
      ready_q        <= (state_d == ST_RUN);
    end
  end

  assign FABRIC_RESET_N = fabric_rst_n_q;
  assign PCIE_RESET_N   = pcie_rst_n_q;
  assign INIT_STATE     = state_q;
  assign TIMEOUT        = timeout_q;
  assign READY          = ready_q;

endmodule

// File: tb/tb_pcie_init_reset_sequencer.sv
// Table-driven bench for the PCIe init/reset sequencer.
module tb_pcie_init_reset_sequencer;

  typedef struct {
    logic       rstn;
    logic [5:0] in;   // {por, pcie_init, dev_init, calib0, calib1, lock}
    int         cyc;
    logic [2:0] st;
    logic       fab;
    logic       pcie;
    logic       to;
    logic       rdy;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic       fab;
    logic       pcie;
    logic       to;
    logic       rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rstn, por, pinit, dinit, c0, c1, lock;
  logic       fab_rst_n, pcie_rst_n, timeout, ready;
  logic [2:0] init_state;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t vecs[$];
  exp_t sb[$];

  localparam logic [5:0] A = 6'b111111;
  localparam logic [5:0] P = 6'b100000;
  localparam logic [5:0] N = 6'b000000;

  always #5 clk = ~clk;

  pcie_init_reset_sequencer #(
    .SYNC_STAGES    (2),
    .HOLD_CYCLES    (256),
    .STAGGER_CYCLES (16),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .CLK                 (clk),
    .RESETN              (rstn),
    .FABRIC_POR_N        (por),
    .PCIE_INIT_DONE      (pinit),
    .DEVICE_INIT_DONE    (dinit),
    .BANK_0_CALIB_STATUS (c0),
    .BANK_1_CALIB_STATUS (c1),
    .PLL_LOCK            (lock),
    .FABRIC_RESET_N      (fab_rst_n),
    .PCIE_RESET_N        (pcie_rst_n),
    .INIT_STATE          (init_state),
    .TIMEOUT             (timeout),
    .READY               (ready)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic add(input logic r, input logic [5:0] in, input int cyc,
                     input logic [2:0] st, input logic fab, input logic pcie,
                     input logic to, input logic rdy);
    vec_t v;
    v.rstn = r; v.in = in; v.cyc = cyc; v.st = st;
    v.fab = fab; v.pcie = pcie; v.to = to; v.rdy = rdy;
    vecs.push_back(v);
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int max_cyc, output int n);
    n = 0;
    while ((init_state !== tgt) && (n < max_cyc)) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    vec_t v;
    exp_t e;
    int   n;

    // All inputs high from reset release
    add(0, A, 3,   0, 0, 0, 0, 0);
    add(1, A, 2,   0, 0, 0, 0, 0);
    add(1, A, 1,   1, 0, 0, 0, 0);
    add(1, A, 3,   4, 0, 0, 0, 0);
    add(1, A, 255, 4, 0, 0, 0, 0);
    add(1, A, 1,   5, 1, 0, 0, 0);
    add(1, A, 15,  5, 1, 0, 0, 0);
    add(1, A, 1,   6, 1, 1, 0, 1);
    // POR loss in RUN, then re-raise
    add(1, 6'b011111, 2, 6, 1, 1, 0, 1);
    add(1, 6'b011111, 1, 0, 0, 0, 0, 0);
    add(1, A, 3,   1, 0, 0, 0, 0);
    add(1, A, 3,   4, 0, 0, 0, 0);
    add(1, A, 256, 5, 1, 0, 0, 0);
    add(1, A, 16,  6, 1, 1, 0, 1);
    // One-cycle lock glitch in RUN
    add(1, 6'b111110, 1, 6, 1, 1, 0, 1);
    add(1, A, 1,   6, 1, 1, 0, 1);
    add(1, A, 1,   3, 0, 0, 0, 0);
    add(1, A, 1,   4, 0, 0, 0, 0);
    // One-cycle lock glitch at HOLD count 100: full hold repeats
    add(1, A, 100, 4, 0, 0, 0, 0);
    add(1, 6'b111110, 1, 4, 0, 0, 0, 0);
    add(1, A, 1,   4, 0, 0, 0, 0);
    add(1, A, 1,   3, 0, 0, 0, 0);
    add(1, A, 1,   4, 0, 0, 0, 0);
    add(1, A, 255, 4, 0, 0, 0, 0);
    add(1, A, 1,   5, 1, 0, 0, 0);
    add(0, A, 1,   0, 0, 0, 0, 0);
    // Inputs raised one group at a time, 50 cycles apart
    add(0, N, 2,   0, 0, 0, 0, 0);
    add(1, N, 50,  0, 0, 0, 0, 0);
    add(1, P, 50,  1, 0, 0, 0, 0);
    add(1, 6'b111000, 50, 2, 0, 0, 0, 0);
    add(1, 6'b111110, 50, 3, 0, 0, 0, 0);
    add(1, A, 50,  4, 0, 0, 0, 0);
    add(1, A, 208, 4, 0, 0, 0, 0);
    add(1, A, 1,   5, 1, 0, 0, 0);
    add(1, A, 16,  6, 1, 1, 0, 1);
    // Timeout in WAIT_INIT, sticky through completion, cleared by reset mid-STAGGER
    add(0, P, 2,    0, 0, 0, 0, 0);
    add(1, P, 1002, 1, 0, 0, 0, 0);
    add(1, P, 1,    1, 0, 0, 1, 0);
    add(1, P, 100,  1, 0, 0, 1, 0);
    add(1, A, 5,    4, 0, 0, 1, 0);
    add(1, A, 256,  5, 1, 0, 1, 0);
    add(0, A, 1,    0, 0, 0, 0, 0);

    rstn = 1'b0;
    {por, pinit, dinit, c0, c1, lock} = A;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rstn = v.rstn;
      {por, pinit, dinit, c0, c1, lock} = v.in;
      e.st = v.st; e.fab = v.fab; e.pcie = v.pcie; e.to = v.to; e.rdy = v.rdy;
      sb.push_back(e);
      repeat (v.cyc) @(negedge clk);
      e = sb.pop_front();
      check($sformatf("v%0d.state", i),    int'(init_state), int'(e.st));
      check($sformatf("v%0d.fabric_n", i), int'(fab_rst_n),  int'(e.fab));
      check($sformatf("v%0d.pcie_n", i),   int'(pcie_rst_n), int'(e.pcie));
      check($sformatf("v%0d.timeout", i),  int'(timeout),    int'(e.to));
      check($sformatf("v%0d.ready", i),    int'(ready),      int'(e.rdy));
    end

    // Init/calib dropping after they passed must not pull the FSM back
    rstn = 1'b1;
    {por, pinit, dinit, c0, c1, lock} = 6'b111110;
    wait_state(3'd3, 20, n);
    check("reach_wait_lock", n, 5);
    {por, pinit, dinit, c0, c1, lock} = 6'b100000;
    repeat (10) @(negedge clk);
    check("latched_status_state", int'(init_state), 3);
    check("latched_status_fab", int'(fab_rst_n), 0);
    {por, pinit, dinit, c0, c1, lock} = 6'b100001;
    wait_state(3'd4, 10, n);
    check("lock_to_hold_latency", n, 3);
    // POR loss during HOLD returns to WAIT_POR after SYNC_STAGES+1 cycles
    repeat (20) @(negedge clk);
    {por, pinit, dinit, c0, c1, lock} = 6'b000001;
    wait_state(3'd0, 10, n);
    check("por_abort_latency", n, 3);
    check("por_abort_fab", int'(fab_rst_n), 0);
    check("por_abort_ready", int'(ready), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
